// File: rtl/serpens_arith_pkg.sv
// Arithmetic helpers shared by the SpMV multiplier datapath.
package serpens_arith_pkg;
    localparam int MAX_MUL_STAGES = 8;
    localparam int CLAMP_W = 128;

    typedef enum logic {TRUNC = 1'b0, SAT = 1'b1} ovf_mode_e;

    // Clamp a sign-extended value to the range of a width-bit signed/unsigned field.
    function automatic logic signed [CLAMP_W-1:0] sat_clamp(
        input logic signed [CLAMP_W-1:0] value,
        input int                        width,
        input logic                      is_signed
    );
        logic signed [CLAMP_W-1:0] lim;
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        logic signed [CLAMP_W-1:0] res;
        lim = {{(CLAMP_W-1){1'b0}}, 1'b1} << (is_signed ? width - 1 : width);
        hi  = lim - CLAMP_W'(1);
        lo  = is_signed ? -lim : '0;
        res = value;
        if (value > hi)
            res = hi;
        else if (value < lo)
            res = lo;
        return res;
    endfunction
endpackage

// File: rtl/serpens_mul_lane.sv
// One multiplier lane: operand register, full product, shift/round/clamp (3 cycles).
// All registers advance only on adv; backpressure is the caller's global stall.
module serpens_mul_lane
    import serpens_arith_pkg::*;
#(
    parameter int A_W      = 32,
    parameter int B_W      = 28,
    parameter int OUT_W    = 32,
    parameter int A_SIGNED = 1,
    parameter int B_SIGNED = 1,
    parameter int SHIFT    = 0,
    parameter int ROUND    = 0,
    parameter int SAT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [OUT_W-1:0] res,
    output logic             ovf
);
    // One spare bit keeps an unsigned x unsigned product positive in signed form.
    localparam int PW = A_W + B_W + 1;
    localparam int RW = PW + 1;
    localparam logic RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] RND = ((ROUND != 0) && (SHIFT > 0)) ? (RW'(1) <<< RND_POS) : '0;
    localparam ovf_mode_e MODE = (SAT != 0) ? serpens_arith_pkg::SAT : TRUNC;

    logic [A_W-1:0]            a_q;
    logic [B_W-1:0]            b_q;
    logic signed [PW-1:0]      prod_q;
    logic signed [A_W:0]       a_ext;
    logic signed [B_W:0]       b_ext;
    logic signed [PW-1:0]      prod_d;
    logic signed [RW-1:0]      rnd_sum;
    logic signed [RW-1:0]      shifted;
    logic signed [CLAMP_W-1:0] r_wide;
    logic signed [CLAMP_W-1:0] r_sat;
    logic [OUT_W-1:0]          res_d;
    logic                      ovf_d;

    always_comb begin
        a_ext   = (A_SIGNED != 0) ? {a_q[A_W-1], a_q} : {1'b0, a_q};
        b_ext   = (B_SIGNED != 0) ? {b_q[B_W-1], b_q} : {1'b0, b_q};
        prod_d  = PW'(a_ext) * PW'(b_ext);
        rnd_sum = RW'(prod_q) + RND;
        shifted = rnd_sum >>> SHIFT;
        r_wide  = CLAMP_W'(shifted);
        r_sat   = sat_clamp(r_wide, OUT_W, RES_SIGNED);
        ovf_d   = (r_sat != r_wide);
        res_d   = (MODE == serpens_arith_pkg::SAT) ? r_sat[OUT_W-1:0] : r_wide[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            res    <= '0;
            ovf    <= 1'b0;
        end else if (adv) begin
            a_q    <= a;
            b_q    <= b;
            prod_q <= prod_d;
            res    <= res_d;
            ovf    <= ovf_d;
        end
    end
endmodule

// File: rtl/serpens_mul_pipe_param.sv
// LANES-wide multiplier pipeline with shift/round/saturate, latency NUM_STAGE adv cycles.
// Global stall: nothing moves when ce=0 or when dout is held by out_ready=0.
module serpens_mul_pipe_param
    import serpens_arith_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int A_W       = 32,
    parameter int B_W       = 28,
    parameter int OUT_W     = 32,
    parameter int NUM_STAGE = 3,
    parameter int A_SIGNED  = 1,
    parameter int B_SIGNED  = 1,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 0,
    parameter int SAT       = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*A_W-1:0]   din0,
    input  logic [LANES*B_W-1:0]   din1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] dout,
    output logic [LANES-1:0]       ovf,
    input  logic                   ovf_clr
);
    logic                   adv;
    logic [NUM_STAGE:1]     vld;
    logic [LANES*OUT_W-1:0] res3;
    logic [LANES-1:0]       ovf3;

    if (NUM_STAGE < 3 || NUM_STAGE > MAX_MUL_STAGES) begin : g_bad_stage
        $error("NUM_STAGE out of range");
    end

    assign adv       = ce & (~out_valid | out_ready);
    assign in_ready  = adv;
    assign out_valid = vld[NUM_STAGE];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serpens_mul_lane #(
            .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W),
            .A_SIGNED(A_SIGNED), .B_SIGNED(B_SIGNED),
            .SHIFT(SHIFT), .ROUND(ROUND), .SAT(SAT)
        ) u_lane (
            .clk(clk),
            .rst(reset),
            .adv(adv),
            .a(din0[i*A_W +: A_W]),
            .b(din1[i*B_W +: B_W]),
            .res(res3[i*OUT_W +: OUT_W]),
            .ovf(ovf3[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld <= '0;
        else if (adv)
            vld <= {vld[NUM_STAGE-1:1], in_valid};
    end

    // Flag is raised as the beat leaves post-processing; a coincident clear loses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= '0;
        else
            ovf <= (ovf & ~{LANES{ovf_clr}}) | (ovf3 & {LANES{adv & vld[3]}});
    end

    if (NUM_STAGE == 3) begin : g_no_delay
        assign dout = res3;
    end else begin : g_delay
        logic [LANES*OUT_W-1:0] dly_q [4:NUM_STAGE];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 4; s <= NUM_STAGE; s++)
                    dly_q[s] <= '0;
            end else if (adv) begin
                dly_q[4] <= res3;
                for (int s = 5; s <= NUM_STAGE; s++)
                    dly_q[s] <= dly_q[s-1];
            end
        end
        assign dout = dly_q[NUM_STAGE];
    end
endmodule

// File: tb/tb_serpens_mul_pipe_param.sv
`timescale 1ns/1ps
module tb_serpens_mul_pipe_param;
    localparam int NS0 = 3;
    localparam int NS1 = 6;

    logic clk = 1'b0;
    logic rst, ce, ovf_clr;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two default-width pipelines (NUM_STAGE 3 and 6) with independent handshakes.
    logic         m_in_valid  [2];
    logic         m_out_ready [2];
    logic         m_in_ready  [2];
    logic         m_out_valid [2];
    logic [127:0] m_din0      [2];
    logic [111:0] m_din1      [2];
    logic [127:0] m_dout      [2];
    logic [3:0]   m_ovf       [2];

    for (genvar g = 0; g < 2; g++) begin : g_main
        serpens_mul_pipe_param #(.NUM_STAGE(g == 0 ? NS0 : NS1)) u_dut (
            .clk(clk), .reset(rst), .ce(ce),
            .in_valid(m_in_valid[g]), .in_ready(m_in_ready[g]),
            .din0(m_din0[g]), .din1(m_din1[g]),
            .out_valid(m_out_valid[g]), .out_ready(m_out_ready[g]),
            .dout(m_dout[g]), .ovf(m_ovf[g]), .ovf_clr(ovf_clr)
        );
    end

    // Arithmetic-option variants sharing one handshake.
    logic         c_in_valid, c_out_ready;
    logic [127:0] c_din0;
    logic [111:0] c_din1;
    logic [31:0]  u_din0, u_din1;
    logic         s_in_ready, s_out_valid, r_in_ready, r_out_valid;
    logic         t_in_ready, t_out_valid, u_in_ready, u_out_valid;
    logic [63:0]  s_dout, u_dout;
    logic [127:0] r_dout, t_dout;
    logic [3:0]   s_ovf, r_ovf, t_ovf, u_ovf;

    serpens_mul_pipe_param #(.OUT_W(16), .SAT(1)) u_sat (
        .clk(clk), .reset(rst), .ce(ce), .in_valid(c_in_valid), .in_ready(s_in_ready),
        .din0(c_din0), .din1(c_din1), .out_valid(s_out_valid), .out_ready(c_out_ready),
        .dout(s_dout), .ovf(s_ovf), .ovf_clr(ovf_clr));
    serpens_mul_pipe_param #(.SHIFT(4), .ROUND(1)) u_rnd (
        .clk(clk), .reset(rst), .ce(ce), .in_valid(c_in_valid), .in_ready(r_in_ready),
        .din0(c_din0), .din1(c_din1), .out_valid(r_out_valid), .out_ready(c_out_ready),
        .dout(r_dout), .ovf(r_ovf), .ovf_clr(ovf_clr));
    serpens_mul_pipe_param #(.SHIFT(4), .ROUND(0)) u_trn (
        .clk(clk), .reset(rst), .ce(ce), .in_valid(c_in_valid), .in_ready(t_in_ready),
        .din0(c_din0), .din1(c_din1), .out_valid(t_out_valid), .out_ready(c_out_ready),
        .dout(t_dout), .ovf(t_ovf), .ovf_clr(ovf_clr));
    serpens_mul_pipe_param #(.A_W(8), .B_W(8), .OUT_W(16), .A_SIGNED(0), .B_SIGNED(0)) u_uns (
        .clk(clk), .reset(rst), .ce(ce), .in_valid(c_in_valid), .in_ready(u_in_ready),
        .din0(u_din0), .din1(u_din1), .out_valid(u_out_valid), .out_ready(c_out_ready),
        .dout(u_dout), .ovf(u_ovf), .ovf_clr(ovf_clr));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer product, optional half-up rounding, floor shift, then fit.
    function automatic logic [63:0] ref_lane(input longint a, input longint b, input int shift,
                                             input bit rnd, input bit sat, input int ow,
                                             input bit sgn, output bit ov);
        longint r, hi, lo;
        r = a * b;
        if (rnd && shift > 0) r = r + (longint'(1) <<< (shift - 1));
        r  = r >>> shift;
        hi = sgn ? (longint'(1) <<< (ow - 1)) - 1 : (longint'(1) <<< ow) - 1;
        lo = sgn ? -(longint'(1) <<< (ow - 1)) : 0;
        ov = (r > hi) || (r < lo);
        if (sat && r > hi) r = hi;
        if (sat && r < lo) r = lo;
        return 64'(r) & ((64'd1 << ow) - 64'd1);
    endfunction

    function automatic logic [127:0] ref_main(input logic [127:0] a, input logic [111:0] b,
                                              output logic [3:0] ov);
        logic [127:0] r;
        bit o;
        for (int i = 0; i < 4; i++) begin
            r[i*32 +: 32] = 32'(ref_lane(longint'($signed(a[i*32 +: 32])),
                                         longint'($signed(b[i*28 +: 28])), 0, 0, 0, 32, 1, o));
            ov[i] = o;
        end
        return r;
    endfunction

    task automatic rand_beat(input int k);
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                m_din0[k][i*32 +: 32] = $urandom;
                m_din1[k][i*28 +: 28] = 28'($urandom);
            end else begin
                m_din0[k][i*32 +: 32] = 32'(int'($urandom_range(0, 2000)) - 1000);
                m_din1[k][i*28 +: 28] = 28'(int'($urandom_range(0, 2000)) - 1000);
            end
        end
    endtask

    task automatic run_main(input int k);
        int ns, lat, sent, recv, cyc;
        logic [127:0] exp_q[$];
        logic [127:0] e;
        logic [3:0]   ov, exp_ovf;
        bit acc;
        ns = (k == 0) ? NS0 : NS1;

        // single beat: -3 * 7
        m_din0[k] = '0;
        m_din1[k] = '0;
        m_din0[k][31:0] = 32'hFFFF_FFFD;
        m_din1[k][27:0] = 28'd7;
        m_out_ready[k] = 1'b1;
        m_in_valid[k] = 1'b1;
        tick();
        m_in_valid[k] = 1'b0;
        lat = 1;
        while (!m_out_valid[k] && lat < 20) begin
            tick();
            lat++;
        end
        chk("t1_latency", 128'(lat), 128'(ns));
        chk("t1_dout_lane0", 128'(m_dout[k][31:0]), 128'(32'hFFFF_FFEB));
        tick();
        chk("t1_single_pulse", 128'(m_out_valid[k]), 128'(1'b0));
        chk("t1_ovf", 128'(m_ovf[k]), 128'(4'b0000));

        // 20-beat stream with out_ready pattern 1,0,0
        exp_ovf = '0;
        sent = 0;
        recv = 0;
        cyc = 0;
        rand_beat(k);
        m_in_valid[k] = 1'b1;
        while (recv < 20 && cyc < 400) begin
            m_out_ready[k] = (cyc % 3 == 0);
            #1;
            chk("t2_in_ready", 128'(m_in_ready[k]), 128'(!(m_out_valid[k] && !m_out_ready[k])));
            if (m_out_valid[k] && m_out_ready[k]) begin
                chk("t2_result_expected", 128'(exp_q.size() != 0), 128'(1'b1));
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                chk("t2_dout", m_dout[k], e);
                recv++;
            end
            acc = m_in_valid[k] && m_in_ready[k];
            if (acc) begin
                exp_q.push_back(ref_main(m_din0[k], m_din1[k], ov));
                exp_ovf |= ov;
                sent++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (sent == 20) m_in_valid[k] = 1'b0;
                else rand_beat(k);
            end
        end
        chk("t2_count", 128'(recv), 128'(20));
        chk("t2_ovf_sticky", 128'(m_ovf[k]), 128'(exp_ovf));
        m_out_ready[k] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_no_duplicate", 128'(m_out_valid[k]), 128'(1'b0));
        end

        // three beats in flight, freeze with ce=0, then reset
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            rand_beat(k);
            exp_q.push_back(ref_main(m_din0[k], m_din1[k], ov));
            m_in_valid[k] = 1'b1;
            tick();
        end
        ce = 1'b0;
        rand_beat(k);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t6_in_ready_frozen", 128'(m_in_ready[k]), 128'(1'b0));
            chk("t6_out_valid_frozen", 128'(m_out_valid[k]), 128'(ns == 3));
            if (ns == 3) chk("t6_dout_frozen", m_dout[k], exp_q[0]);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("t6_reset_out_valid", 128'(m_out_valid[k]), 128'(1'b0));
        chk("t6_reset_ovf", 128'(m_ovf[k]), 128'(4'b0000));
        tick();
        rst = 1'b0;
        ce = 1'b1;
        m_in_valid[k] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_no_stale_beat", 128'(m_out_valid[k]), 128'(1'b0));
        end
    endtask

    initial begin
        int av [4];
        int bv [4];
        int lat;
        logic [3:0] s_exp_ovf, r_exp_ovf, t_exp_ovf, u_exp_ovf;
        bit o;

        av = '{3, 300, -300, -5};
        bv = '{8, 300, 300, 3};
        rst = 1'b1;
        ce = 1'b1;
        ovf_clr = 1'b0;
        c_in_valid = 1'b0;
        c_out_ready = 1'b1;
        c_din0 = '0;
        c_din1 = '0;
        u_din0 = '0;
        u_din1 = '0;
        for (int k = 0; k < 2; k++) begin
            m_in_valid[k] = 1'b0;
            m_out_ready[k] = 1'b1;
            m_din0[k] = '0;
            m_din1[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("reset_out_valid", 128'(m_out_valid[k]), 128'(1'b0));
            chk("reset_ovf", 128'(m_ovf[k]), 128'(4'b0000));
            chk("reset_dout", m_dout[k], 128'(0));
            chk("reset_in_ready", 128'(m_in_ready[k]), 128'(1'b1));
        end
        chk("reset_cfg_in_ready", 128'({s_in_ready, r_in_ready, t_in_ready, u_in_ready}), 128'(4'hF));
        rst = 1'b0;
        tick();

        run_main(0);
        run_main(1);

        // saturation, rounding, truncating shift and unsigned variants
        for (int i = 0; i < 4; i++) begin
            c_din0[i*32 +: 32] = av[i];
            c_din1[i*28 +: 28] = 28'(bv[i]);
            u_din0[i*8 +: 8] = (i == 0) ? 8'd255 : 8'($urandom);
            u_din1[i*8 +: 8] = (i == 0) ? 8'd255 : 8'($urandom);
        end
        c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("cfg_latency", 128'(lat), 128'(3));
        chk("cfg_out_valid", 128'({r_out_valid, t_out_valid, u_out_valid}), 128'(3'b111));
        chk("t3_sat_pos", 128'(s_dout[31:16]), 128'(16'h7FFF));
        chk("t3_sat_neg", 128'(s_dout[47:32]), 128'(16'h8000));
        chk("t4_round_24", 128'(r_dout[31:0]), 128'(32'd2));
        chk("t4_round_m15", 128'(r_dout[127:96]), 128'(32'hFFFF_FFFF));
        chk("t4_trunc_24", 128'(t_dout[31:0]), 128'(32'd1));
        chk("t5_unsigned_max", 128'(u_dout[15:0]), 128'(16'd65025));
        for (int i = 0; i < 4; i++) begin
            chk("t3_sat_model", 128'(s_dout[i*16 +: 16]),
                128'(ref_lane(longint'(av[i]), longint'(bv[i]), 0, 0, 1, 16, 1, o)));
            s_exp_ovf[i] = o;
            chk("t4_round_model", 128'(r_dout[i*32 +: 32]),
                128'(ref_lane(longint'(av[i]), longint'(bv[i]), 4, 1, 0, 32, 1, o)));
            r_exp_ovf[i] = o;
            chk("t4_trunc_model", 128'(t_dout[i*32 +: 32]),
                128'(ref_lane(longint'(av[i]), longint'(bv[i]), 4, 0, 0, 32, 1, o)));
            t_exp_ovf[i] = o;
            chk("t5_unsigned_model", 128'(u_dout[i*16 +: 16]),
                128'(ref_lane(longint'(u_din0[i*8 +: 8]), longint'(u_din1[i*8 +: 8]), 0, 0, 0, 16, 0, o)));
            u_exp_ovf[i] = o;
        end
        tick();
        chk("t3_ovf_lane1", 128'(s_ovf[1]), 128'(1'b1));
        chk("t3_ovf_model", 128'(s_ovf), 128'(s_exp_ovf));
        chk("t4_round_ovf", 128'(r_ovf), 128'(r_exp_ovf));
        chk("t4_trunc_ovf", 128'(t_ovf), 128'(t_exp_ovf));
        chk("t5_unsigned_ovf", 128'(u_ovf), 128'(u_exp_ovf));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_cleared", 128'(s_ovf), 128'(4'b0000));

        // clear coinciding with a new overflowing beat leaving: set wins
        c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("t3_second_latency", 128'(lat), 128'(3));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_set_beats_clear", 128'(s_ovf), 128'(s_exp_ovf));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
